ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage for the 64-bit LEGv8 datapath. It captures decoded operands and control each cycle, then resolves RAW hazards by forwarding from the MEM and WB stages. It presents the final `a`, `b` and `ALUControl` to the execute-stage ALU, plus forwarded store data for the MEM stage. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- `N`, 64: datapath width.
- `ZR`, 31: register index hard-wired to zero (XZR); never forwarded.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold the E-stage register.
- `flush`  in  1  load a bubble into the E-stage register.
- `valid_D`  in  1  decode slot holds a real instruction.
- `readData1_D`, `readData2_D`  in  N  register-file read data.
- `signImm_D`  in  N  sign-extended immediate.
- `Rn_D`, `Rm_D`, `Rd_D`  in  5  source and destination indices.
- `ALUSrc_D`  in  1  b operand select: 1 = immediate, 0 = register.
- `ALUControl_D`  in  4  ALU opcode (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B).
- `regWrite_D`, `memWrite_D`, `memRead_D`  in  1  control bits.
- `aluResult_M`  in  N  EX/MEM result; `Rd_M` in 5; `regWrite_M` in 1.
- `writeData_W`  in  N  MEM/WB write-back value; `Rd_W` in 5; `regWrite_W` in 1.
- `a_E`, `b_E`  out  N  ALU operands.
- `ALUControl_E`  out  4  registered opcode.
- `writeData_E`  out  N  forwarded store data (register path, never the immediate).
- `Rd_E`  out  5; `regWrite_E`, `memWrite_E`, `memRead_E`, `valid_E`  out  1.
- `fwdA_E`, `fwdB_E`  out  2  forwarding select, for debug/coverage (00 register, 10 from M, 01 from W).

## Operation
- E-stage register update priority at each rising edge: `reset` > `flush` > `stall` > load.
  - `reset` or `flush`: every registered field is cleared to 0, so `valid_E=0`, `regWrite_E=0`, `memWrite_E=0`, `memRead_E=0`, `ALUControl_E=0000`, and all data and index fields are 0.
  - `stall` (without flush): all fields hold their value.
  - Otherwise: all `*_D` inputs are captured into the matching E fields.
- Forwarding is combinational from the registered E fields and the live M/W inputs. For operand A:
  - if `regWrite_M` and `Rd_M != ZR` and `Rd_M == Rn_E`: select `aluResult_M`, fwdA=10;
  - else if `regWrite_W` and `Rd_W != ZR` and `Rd_W == Rn_E`: select `writeData_W`, fwdA=01;
  - else select `readData1_E`, fwdA=00.
- Operand B uses the same rule with `Rm_E` and `readData2_E`. M beats W when both match.
- `a_E` = forwarded A. `writeData_E` = forwarded B. `b_E` = `signImm_E` if `ALUSrc_E`, else forwarded B.
- Forwarding does not depend on `valid_E`. A bubble carries index 0 and regWrite 0, so it is harmless downstream.
- Load-use hazards are detected outside this block. The hazard unit asserts `stall` upstream and `flush` here.
- No arithmetic is performed. Widths pass through unchanged.

## Timing
- Latency: 1 cycle from D inputs to E registered outputs. The forwarding path is 0-cycle combinational from M/W inputs to `a_E`, `b_E` and `writeData_E`.
- Reset values: all registered outputs are 0. With `regWrite_M=regWrite_W=0`, `a_E=b_E=writeData_E=0` and `fwdA_E=fwdB_E=00`.
- Reset asserted mid-stream clears the stage on the same edge, overriding `stall` and `flush`.
- `flush` and `stall` asserted together: flush wins and a bubble is loaded.
- A stalled cycle still re-evaluates forwarding every cycle, so a held instruction picks up newly arriving M/W results.
- `Rd_M == Rd_W == Rn_E` with both writing: the M value is selected.
- Index 31: reads come from the register file (expected 0) and are never overridden by forwarding, even when `Rd_M=31` and `regWrite_M=1`.

## Test plan
- Reset, then idle with `regWrite_M/W=0` -> all outputs 0, `ALUControl_E=0000`, `valid_E=0`.
- Load `Rn=1`, `Rm=2`, `readData1=5`, `readData2=7`, `ALUSrc=0`, `ALUControl=0010`, no matches -> next cycle `a_E=5`, `b_E=7`, `fwdA/B=00`. Repeat with `ALUSrc=1`, `signImm=-4` -> `b_E=0xFFFF_FFFF_FFFF_FFFC`, `writeData_E=7`.
- E holds `Rn=3`; drive `Rd_M=3`, `regWrite_M=1`, `aluResult_M=0x10` and `Rd_W=3`, `regWrite_W=1`, `writeData_W=0x20` -> `a_E=0x10`, fwdA=10. Drop `regWrite_M` -> `a_E=0x20`, fwdA=01.
- E holds `Rn=31`, `readData1=0`; drive `Rd_M=31`, `regWrite_M=1`, `aluResult_M=0xDEAD` -> `a_E=0`, fwdA=00.
- Assert `stall` for 3 cycles while changing D inputs -> E fields unchanged. Meanwhile drive W forwarding to `Rm_E` -> `b_E` tracks `writeData_W` each cycle.
- Assert `stall` and `flush` together with `regWrite_D=1` -> next cycle `valid_E=0`, `regWrite_E=0`, `memWrite_E=0`. Assert `reset` during a stall -> all fields 0 on the next edge.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// The ID/EX pipeline register and operand-forwarding stage for the 64-bit
// LEGv8 datapath.
//
// Each cycle the stage captures the decoded operands and control into the
// E-stage register. It then resolves read-after-write hazards against the
// instructions currently in MEM and WB. The result is the final ALU operands,
// the ALU opcode, and the forwarded store data for the MEM stage.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall, flush        hazard-unit controls for the E-stage register
//   *_D                 decoded instruction fields from the decode stage
//   aluResult_M, Rd_M,
//   regWrite_M          result and destination of the instruction in MEM
//   writeData_W, Rd_W,
//   regWrite_W          write-back value and destination of the instruction
//                       in WB
//   a_E, b_E            ALU operands after forwarding and immediate select
//   ALUControl_E        registered ALU opcode
//   writeData_E         forwarded store data (register path only)
//   Rd_E, regWrite_E,
//   memWrite_E,
//   memRead_E, valid_E  registered control passed on to MEM
//   fwdA_E, fwdB_E      forwarding selects (00 reg file, 10 MEM, 01 WB)
// ---------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int unsigned N  = 64,
    parameter logic [4:0]  ZR = 5'd31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,

    input  logic         valid_D,
    input  logic [N-1:0] readData1_D,
    input  logic [N-1:0] readData2_D,
    input  logic [N-1:0] signImm_D,
    input  logic [4:0]   Rn_D,
    input  logic [4:0]   Rm_D,
    input  logic [4:0]   Rd_D,
    input  logic         ALUSrc_D,
    input  logic [3:0]   ALUControl_D,
    input  logic         regWrite_D,
    input  logic         memWrite_D,
    input  logic         memRead_D,

    input  logic [N-1:0] aluResult_M,
    input  logic [4:0]   Rd_M,
    input  logic         regWrite_M,

    input  logic [N-1:0] writeData_W,
    input  logic [4:0]   Rd_W,
    input  logic         regWrite_W,

    output logic [N-1:0] a_E,
    output logic [N-1:0] b_E,
    output logic [3:0]   ALUControl_E,
    output logic [N-1:0] writeData_E,
    output logic [4:0]   Rd_E,
    output logic         regWrite_E,
    output logic         memWrite_E,
    output logic         memRead_E,
    output logic         valid_E,
    output logic [1:0]   fwdA_E,
    output logic [1:0]   fwdB_E
);

    // Forwarding select encodings.
    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdMem = 2'b10;
    localparam logic [1:0] FwdWb  = 2'b01;

    // -----------------------------------------------------------------------
    // E-stage register contents
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic         valid;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [N-1:0] imm;
        logic [4:0]   rn;
        logic [4:0]   rm;
        logic [4:0]   rd;
        logic         alusrc;
        logic [3:0]   aluctl;
        logic         regwrite;
        logic         memwrite;
        logic         memread;
    } e_fields_t;

    e_fields_t dec_fields;
    e_fields_t e_d;
    e_fields_t e_q;

    // Gather the decode-stage fields into one bundle.
    always_comb begin
        dec_fields          = '0;
        dec_fields.valid    = valid_D;
        dec_fields.rd1      = readData1_D;
        dec_fields.rd2      = readData2_D;
        dec_fields.imm      = signImm_D;
        dec_fields.rn       = Rn_D;
        dec_fields.rm       = Rm_D;
        dec_fields.rd       = Rd_D;
        dec_fields.alusrc   = ALUSrc_D;
        dec_fields.aluctl   = ALUControl_D;
        dec_fields.regwrite = regWrite_D;
        dec_fields.memwrite = memWrite_D;
        dec_fields.memread  = memRead_D;
    end

    // Next state: flush beats stall, so a flushed slot always becomes a bubble
    // even when the hazard unit also holds the stage. Reset is applied in the
    // flop and overrides both.
    always_comb begin
        e_d = e_q;
        if (flush) begin
            e_d = '0;
        end else if (!stall) begin
            e_d = dec_fields;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding
    // -----------------------------------------------------------------------
    // MEM is younger than WB, so it takes priority. XZR is never a forwarding
    // target: a write to it is architecturally discarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] rd_m,
        input logic       rw_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = FwdReg;
        if (rw_m && (rd_m != ZR) && (rd_m == src)) begin
            sel = FwdMem;
        end else if (rw_w && (rd_w != ZR) && (rd_w == src)) begin
            sel = FwdWb;
        end
        return sel;
    endfunction

    logic [1:0]   fwd_a;
    logic [1:0]   fwd_b;
    logic [N-1:0] opnd_a;
    logic [N-1:0] opnd_b;

    // This path is evaluated even while the stage is stalled. A held
    // instruction can then pick up a producer that arrives in MEM or WB
    // during the stall.
    always_comb begin
        fwd_a = fwd_sel(e_q.rn, regWrite_M, Rd_M, regWrite_W, Rd_W);
        fwd_b = fwd_sel(e_q.rm, regWrite_M, Rd_M, regWrite_W, Rd_W);
    end

    always_comb begin
        opnd_a = e_q.rd1;
        case (fwd_a)
            FwdMem:  opnd_a = aluResult_M;
            FwdWb:   opnd_a = writeData_W;
            default: opnd_a = e_q.rd1;
        endcase
    end

    always_comb begin
        opnd_b = e_q.rd2;
        case (fwd_b)
            FwdMem:  opnd_b = aluResult_M;
            FwdWb:   opnd_b = writeData_W;
            default: opnd_b = e_q.rd2;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Store data always takes the register path. For STUR, the immediate
    // feeds the address add while the forwarded Rt value is what gets stored.
    assign a_E          = opnd_a;
    assign b_E          = e_q.alusrc ? e_q.imm : opnd_b;
    assign writeData_E  = opnd_b;
    assign ALUControl_E = e_q.aluctl;
    assign Rd_E         = e_q.rd;
    assign regWrite_E   = e_q.regwrite;
    assign memWrite_E   = e_q.memwrite;
    assign memRead_E    = e_q.memread;
    assign valid_E      = e_q.valid;
    assign fwdA_E       = fwd_a;
    assign fwdB_E       = fwd_b;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Scoreboard bench for ex_operand_stage.
//
// The driver updates a reference E-stage register on every rising edge. It
// then drives the MEM/WB inputs and pushes the expected outputs to a queue. A
// monitor pops the queue on the falling edge and compares. Directed scenarios
// add fixed-value checks on top of the scoreboard.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

    localparam int unsigned N = 64;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         flush;
    logic         valid_D;
    logic [N-1:0] readData1_D;
    logic [N-1:0] readData2_D;
    logic [N-1:0] signImm_D;
    logic [4:0]   Rn_D;
    logic [4:0]   Rm_D;
    logic [4:0]   Rd_D;
    logic         ALUSrc_D;
    logic [3:0]   ALUControl_D;
    logic         regWrite_D;
    logic         memWrite_D;
    logic         memRead_D;
    logic [N-1:0] aluResult_M;
    logic [4:0]   Rd_M;
    logic         regWrite_M;
    logic [N-1:0] writeData_W;
    logic [4:0]   Rd_W;
    logic         regWrite_W;
    logic [N-1:0] a_E;
    logic [N-1:0] b_E;
    logic [3:0]   ALUControl_E;
    logic [N-1:0] writeData_E;
    logic [4:0]   Rd_E;
    logic         regWrite_E;
    logic         memWrite_E;
    logic         memRead_E;
    logic         valid_E;
    logic [1:0]   fwdA_E;
    logic [1:0]   fwdB_E;

    ex_operand_stage #(
        .N  (64),
        .ZR (5'd31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .valid_D      (valid_D),
        .readData1_D  (readData1_D),
        .readData2_D  (readData2_D),
        .signImm_D    (signImm_D),
        .Rn_D         (Rn_D),
        .Rm_D         (Rm_D),
        .Rd_D         (Rd_D),
        .ALUSrc_D     (ALUSrc_D),
        .ALUControl_D (ALUControl_D),
        .regWrite_D   (regWrite_D),
        .memWrite_D   (memWrite_D),
        .memRead_D    (memRead_D),
        .aluResult_M  (aluResult_M),
        .Rd_M         (Rd_M),
        .regWrite_M   (regWrite_M),
        .writeData_W  (writeData_W),
        .Rd_W         (Rd_W),
        .regWrite_W   (regWrite_W),
        .a_E          (a_E),
        .b_E          (b_E),
        .ALUControl_E (ALUControl_E),
        .writeData_E  (writeData_E),
        .Rd_E         (Rd_E),
        .regWrite_E   (regWrite_E),
        .memWrite_E   (memWrite_E),
        .memRead_E    (memRead_E),
        .valid_E      (valid_E),
        .fwdA_E       (fwdA_E),
        .fwdB_E       (fwdB_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model state
    // -----------------------------------------------------------------------
    logic         m_valid;
    logic [N-1:0] m_rd1;
    logic [N-1:0] m_rd2;
    logic [N-1:0] m_imm;
    logic [4:0]   m_rn;
    logic [4:0]   m_rm;
    logic [4:0]   m_rd;
    logic         m_alusrc;
    logic [3:0]   m_ctl;
    logic         m_rw;
    logic         m_mw;
    logic         m_mr;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] wd;
        logic [3:0]   ctl;
        logic [4:0]   rd;
        logic         rw;
        logic         mw;
        logic         mr;
        logic         v;
        logic [1:0]   fa;
        logic [1:0]   fb;
    } exp_t;

    exp_t sb[$];

    // Model clock edge: reset > flush > stall > load.
    task automatic step();
        @(posedge clk);
        if (reset || flush) begin
            m_valid = 1'b0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_rn = '0; m_rm = '0; m_rd = '0; m_alusrc = 1'b0; m_ctl = '0;
            m_rw = 1'b0; m_mw = 1'b0; m_mr = 1'b0;
        end else if (!stall) begin
            m_valid = valid_D; m_rd1 = readData1_D; m_rd2 = readData2_D;
            m_imm = signImm_D; m_rn = Rn_D; m_rm = Rm_D; m_rd = Rd_D;
            m_alusrc = ALUSrc_D; m_ctl = ALUControl_D; m_rw = regWrite_D;
            m_mw = memWrite_D; m_mr = memRead_D;
        end
        #1;
    endtask

    function automatic logic [1:0] ref_sel(input logic [4:0] src);
        if (regWrite_M && Rd_M != 5'd31 && Rd_M == src) return 2'b10;
        if (regWrite_W && Rd_W != 5'd31 && Rd_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [N-1:0] ref_val(input logic [1:0] sel, input logic [N-1:0] regv);
        if (sel == 2'b10) return aluResult_M;
        if (sel == 2'b01) return writeData_W;
        return regv;
    endfunction

    task automatic sb_push();
        exp_t e;
        e.fa  = ref_sel(m_rn);
        e.fb  = ref_sel(m_rm);
        e.a   = ref_val(e.fa, m_rd1);
        e.wd  = ref_val(e.fb, m_rd2);
        e.b   = m_alusrc ? m_imm : e.wd;
        e.ctl = m_ctl;
        e.rd  = m_rd;
        e.rw  = m_rw;
        e.mw  = m_mw;
        e.mr  = m_mr;
        e.v   = m_valid;
        sb.push_back(e);
    endtask

    // Monitor: compare outputs on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_a",    a_E,          e.a);
            check("sb_b",    b_E,          e.b);
            check("sb_wd",   writeData_E,  e.wd);
            check("sb_ctl",  64'(ALUControl_E), 64'(e.ctl));
            check("sb_rd",   64'(Rd_E),    64'(e.rd));
            check("sb_rw",   64'(regWrite_E), 64'(e.rw));
            check("sb_mw",   64'(memWrite_E), 64'(e.mw));
            check("sb_mr",   64'(memRead_E),  64'(e.mr));
            check("sb_v",    64'(valid_E),    64'(e.v));
            check("sb_fwdA", 64'(fwdA_E),     64'(e.fa));
            check("sb_fwdB", 64'(fwdB_E),     64'(e.fb));
        end
    end

    // -----------------------------------------------------------------------
    // Drive helpers
    // -----------------------------------------------------------------------
    task automatic set_d(input logic v, input logic [N-1:0] r1, input logic [N-1:0] r2,
                         input logic [N-1:0] imm, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic src, input logic [3:0] ctl,
                         input logic rw, input logic mw, input logic mr);
        valid_D = v; readData1_D = r1; readData2_D = r2; signImm_D = imm;
        Rn_D = rn; Rm_D = rm; Rd_D = rd; ALUSrc_D = src; ALUControl_D = ctl;
        regWrite_D = rw; memWrite_D = mw; memRead_D = mr;
    endtask

    task automatic set_mw(input logic [N-1:0] am, input logic [4:0] rdm, input logic rwm,
                          input logic [N-1:0] ww, input logic [4:0] rdw, input logic rww);
        aluResult_M = am; Rd_M = rdm; regWrite_M = rwm;
        writeData_W = ww; Rd_W = rdw; regWrite_W = rww;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_idx();
        int unsigned r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_valid = 1'b0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_rn = '0; m_rm = '0;
        m_rd = '0; m_alusrc = 1'b0; m_ctl = '0; m_rw = 1'b0; m_mw = 1'b0; m_mr = 1'b0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_d(1'b1, 64'h55, 64'h66, 64'h77, 5'd1, 5'd2, 5'd3, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
        set_mw('0, '0, 1'b0, '0, '0, 1'b0);

        // Reset, idle.
        step();
        sb_push();
        at_neg();
        check("rst_a",     a_E, 64'd0);
        check("rst_b",     b_E, 64'd0);
        check("rst_ctl",   64'(ALUControl_E), 64'd0);
        check("rst_valid", 64'(valid_E), 64'd0);

        // Plain register operands.
        reset = 1'b0;
        set_d(1'b1, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd4, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        sb_push();
        at_neg();
        check("load_a",    a_E, 64'd5);
        check("load_b",    b_E, 64'd7);
        check("load_fwdA", 64'(fwdA_E), 64'd0);
        check("load_fwdB", 64'(fwdB_E), 64'd0);

        // Immediate operand; store data stays on register path.
        set_d(1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd2, 5'd4, 1'b1, 4'b0010,
              1'b1, 1'b0, 1'b0);
        step();
        sb_push();
        at_neg();
        check("imm_b",  b_E, 64'hFFFF_FFFF_FFFF_FFFC);
        check("imm_wd", writeData_E, 64'd7);

        // M and W both match Rn: M wins.
        set_d(1'b1, 64'd9, 64'd11, 64'd0, 5'd3, 5'd6, 5'd5, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        set_mw(64'h10, 5'd3, 1'b1, 64'h20, 5'd3, 1'b1);
        sb_push();
        at_neg();
        check("fwdM_a",    a_E, 64'h10);
        check("fwdM_sel",  64'(fwdA_E), 64'h2);

        // Hold the instruction, drop regWrite_M: W supplies A.
        stall = 1'b1;
        step();
        set_mw(64'h10, 5'd3, 1'b0, 64'h20, 5'd3, 1'b1);
        sb_push();
        at_neg();
        check("fwdW_a",   a_E, 64'h20);
        check("fwdW_sel", 64'(fwdA_E), 64'h1);

        // XZR is never forwarded.
        stall = 1'b0;
        set_d(1'b1, 64'd0, 64'd0, 64'd0, 5'd31, 5'd31, 5'd1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        set_mw(64'hDEAD, 5'd31, 1'b1, 64'hBEEF, 5'd31, 1'b1);
        sb_push();
        at_neg();
        check("zr_a",   a_E, 64'd0);
        check("zr_sel", 64'(fwdA_E), 64'd0);

        // Three stalled cycles with changing D; W forwarding into Rm tracks.
        set_d(1'b1, 64'h100, 64'h200, 64'd0, 5'd7, 5'd8, 5'd9, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        step();
        set_mw('0, '0, 1'b0, '0, '0, 1'b0);
        sb_push();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_d(1'b0, 64'(i + 40), 64'(i + 50), 64'(i), 5'(i + 10), 5'(i + 12), 5'(i + 14),
                  1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
            step();
            set_mw('0, '0, 1'b0, 64'h1000 + 64'(i), 5'd8, 1'b1);
            sb_push();
            at_neg();
            check("stall_b",   b_E, 64'h1000 + 64'(i));
            check("stall_rd",  64'(Rd_E), 64'd9);
            check("stall_ctl", 64'(ALUControl_E), 64'h6);
        end

        // Flush together with stall: bubble.
        flush = 1'b1;
        set_d(1'b1, 64'd1, 64'd2, 64'd3, 5'd4, 5'd5, 5'd6, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
        step();
        stall = 1'b0; flush = 1'b0;
        set_mw('0, '0, 1'b0, '0, '0, 1'b0);
        sb_push();
        at_neg();
        check("flush_valid", 64'(valid_E), 64'd0);
        check("flush_rw",    64'(regWrite_E), 64'd0);
        check("flush_mw",    64'(memWrite_E), 64'd0);

        // Reset during a stall clears everything.
        step();
        sb_push();
        stall = 1'b1; reset = 1'b1;
        step();
        sb_push();
        at_neg();
        check("rst_stall_rd1", a_E, 64'd0);
        check("rst_stall_rd",  64'(Rd_E), 64'd0);
        check("rst_stall_v",   64'(valid_E), 64'd0);
        stall = 1'b0; reset = 1'b0;

        // Both M and W target Rm: M wins on B.
        set_d(1'b1, 64'd1, 64'd2, 64'd0, 5'd4, 5'd5, 5'd6, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        set_mw(64'hAA, 5'd5, 1'b1, 64'hBB, 5'd5, 1'b1);
        sb_push();
        at_neg();
        check("mw_b",   b_E, 64'hAA);
        check("mw_sel", 64'(fwdB_E), 64'h2);

        // Random traffic with dense index collisions.
        for (int i = 0; i < 200; i++) begin
            set_d(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, pick_idx(), pick_idx(), pick_idx(),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 29) == 0);
            step();
            set_mw({$urandom, $urandom}, pick_idx(), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, pick_idx(), 1'($urandom_range(0, 1)));
            sb_push();
        end
        stall = 1'b0; flush = 1'b0; reset = 1'b0;

        at_neg();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
